// File: rtl/bus_arbiter_reg_pkg.sv
// Shared constants for the registered internal bus arbiter and its sources.
package bus_arbiter_reg_pkg;

    localparam int BUS_WIDTH = 32;

    localparam int SRC_PC  = 0;
    localparam int SRC_IR  = 1;
    localparam int SRC_MAR = 2;
    localparam int SRC_MDR = 3;
    localparam int SRC_R0  = 4;
    localparam int SRC_R1  = 5;
    localparam int SRC_R2  = 6;
    localparam int SRC_R3  = 7;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/bus_arbiter_reg_if.sv
// Source-side and result-side signals of the internal bus arbiter.
interface bus_arbiter_reg_if
    import bus_arbiter_reg_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = 8,
    parameter int CNT_W = 8,
    localparam int SEL_W = $clog2(NSRC)
);

    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_oe;
    logic                  clr_err;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [SEL_W-1:0]      bus_src;
    logic                  conflict;
    logic [CNT_W-1:0]      conflict_cnt;

    modport master (
        output src_data, src_oe, clr_err,
        input  bus_out, bus_valid, bus_src, conflict, conflict_cnt
    );

    modport slave (
        input  src_data, src_oe, clr_err,
        output bus_out, bus_valid, bus_src, conflict, conflict_cnt
    );

endinterface

// File: rtl/bus_arbiter_reg_prio_pick.sv
// Circular priority picker: first set request scanning upward from start.
module bus_arbiter_reg_prio_pick #(
    parameter int unsigned N = 8,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] start,
    output logic [SW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned j;
        logic        found;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(start) + i) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = SW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_reg.sv
// Registered internal bus multiplexer with conflict detection, a saturating
// conflict counter and fixed-priority or round-robin resolution.
module bus_arbiter_reg
    import bus_arbiter_reg_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = 8,
    parameter int MODE  = ARB_FIXED,
    parameter int CNT_W = 8,
    localparam int SEL_W = $clog2(NSRC)
) (
    input logic              clk,
    input logic              rst_n,
    bus_arbiter_reg_if.slave bus
);

    logic [WIDTH-1:0] words [NSRC];
    logic [SEL_W-1:0] win;
    logic             any_req;
    logic             multi;

    logic [WIDTH-1:0] bus_q;
    logic [SEL_W-1:0] src_q;
    logic             valid_q;
    logic             conf_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            words[i] = bus.src_data[i*WIDTH +: WIDTH];
        end
    end

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign multi = |(bus.src_oe & (bus.src_oe - 1'b1));

    generate
        if (MODE == ARB_RR) begin : g_rr
            logic [SEL_W-1:0] rr_last;
            logic [SEL_W-1:0] start;

            assign start = (rr_last == SEL_W'(NSRC-1)) ? '0 : rr_last + 1'b1;

            bus_arbiter_reg_prio_pick #(.N(NSRC)) u_pick (
                .req   (bus.src_oe),
                .start (start),
                .idx   (win),
                .any   (any_req)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_last <= SEL_W'(NSRC-1);
                end else if (any_req) begin
                    rr_last <= win;
                end
            end
        end else begin : g_fixed
            logic [NSRC-1:0]  rev;
            logic [SEL_W-1:0] ridx;

            // Reversed vector with start 0 makes the highest original index win.
            always_comb begin
                for (int unsigned i = 0; i < NSRC; i++) begin
                    rev[i] = bus.src_oe[NSRC-1-i];
                end
            end

            bus_arbiter_reg_prio_pick #(.N(NSRC)) u_pick (
                .req   (rev),
                .start ('0),
                .idx   (ridx),
                .any   (any_req)
            );

            assign win = SEL_W'(NSRC-1) - ridx;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q   <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
            conf_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= any_req;
            conf_q  <= multi;
            if (any_req) begin
                bus_q <= words[win];
                src_q <= win;
            end
            if (bus.clr_err) begin
                cnt_q <= CNT_W'(multi);
            end else if (multi && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.bus_out      = bus_q;
    assign bus.bus_src      = src_q;
    assign bus.bus_valid    = valid_q;
    assign bus.conflict     = conf_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_reg.sv
// Directed bench: fixed-priority, round-robin and 4-bit-counter arbiters share one stimulus.
module tb_bus_arbiter_reg;

    logic         clk;
    logic         rst_n;
    logic [255:0] sdata;
    logic [7:0]   oe;
    logic         clr;

    int checks = 0;
    int errors = 0;

    bus_arbiter_reg_if #(.WIDTH(32), .NSRC(8), .CNT_W(8)) if0 ();
    bus_arbiter_reg_if #(.WIDTH(32), .NSRC(8), .CNT_W(8)) if1 ();
    bus_arbiter_reg_if #(.WIDTH(32), .NSRC(8), .CNT_W(4)) if2 ();

    assign if0.src_data = sdata;
    assign if0.src_oe   = oe;
    assign if0.clr_err  = clr;
    assign if1.src_data = sdata;
    assign if1.src_oe   = oe;
    assign if1.clr_err  = clr;
    assign if2.src_data = sdata;
    assign if2.src_oe   = oe;
    assign if2.clr_err  = clr;

    bus_arbiter_reg #(.WIDTH(32), .NSRC(8), .MODE(0), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    bus_arbiter_reg #(.WIDTH(32), .NSRC(8), .MODE(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    bus_arbiter_reg #(.WIDTH(32), .NSRC(8), .MODE(0), .CNT_W(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] oe;
        logic       clr;
        logic [2:0] s0;
        logic [2:0] s1;
        logic       valid;
        logic       conf;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [31:0] word(input int k);
        if (k == 0) return 32'hA0A0_A0A0;
        if (k == 2) return 32'hDEAD_BEEF;
        return 32'h1111_1111 * k;
    endfunction

    task automatic set_words();
        for (int k = 0; k < 8; k++) sdata[k*32 +: 32] = word(k);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] rot [4];

        //              oe     clr  s0  s1  valid conf cnt
        tbl[0]  = '{8'h04, 1'b0, 3'd2, 3'd2, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{8'h00, 1'b0, 3'd2, 3'd2, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{8'h12, 1'b0, 3'd4, 3'd4, 1'b1, 1'b1, 8'd1};
        tbl[3]  = '{8'h12, 1'b0, 3'd4, 3'd1, 1'b1, 1'b1, 8'd2};
        tbl[4]  = '{8'h09, 1'b0, 3'd3, 3'd3, 1'b1, 1'b1, 8'd3};
        tbl[5]  = '{8'h09, 1'b0, 3'd3, 3'd0, 1'b1, 1'b1, 8'd4};
        tbl[6]  = '{8'h09, 1'b0, 3'd3, 3'd3, 1'b1, 1'b1, 8'd5};
        tbl[7]  = '{8'h20, 1'b1, 3'd5, 3'd5, 1'b1, 1'b0, 8'd0};
        tbl[8]  = '{8'hC0, 1'b1, 3'd7, 3'd6, 1'b1, 1'b1, 8'd1};
        tbl[9]  = '{8'hFF, 1'b0, 3'd7, 3'd7, 1'b1, 1'b1, 8'd2};
        tbl[10] = '{8'hFF, 1'b0, 3'd7, 3'd0, 1'b1, 1'b1, 8'd3};
        tbl[11] = '{8'h00, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0, 8'd3};
        tbl[12] = '{8'h01, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 8'd3};
        tbl[13] = '{8'h80, 1'b0, 3'd7, 3'd7, 1'b1, 1'b0, 8'd3};

        rst_n = 1'b1;
        oe    = '0;
        clr   = 1'b0;
        set_words();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst u0.bus_out", if0.bus_out, 32'h0);
        chk("rst u0.bus_src", 32'(if0.bus_src), 32'd0);
        chk("rst u0.valid", 32'(if0.bus_valid), 32'd0);
        chk("rst u0.conflict", 32'(if0.conflict), 32'd0);
        chk("rst u0.cnt", 32'(if0.conflict_cnt), 32'd0);
        chk("rst u1.bus_src", 32'(if1.bus_src), 32'd0);
        chk("rst u2.cnt", 32'(if2.conflict_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            oe  = tbl[i].oe;
            clr = tbl[i].clr;
            step();
            chk($sformatf("v%0d u0.src", i), 32'(if0.bus_src), 32'(tbl[i].s0));
            chk($sformatf("v%0d u0.bus_out", i), if0.bus_out, word(int'(tbl[i].s0)));
            chk($sformatf("v%0d u1.src", i), 32'(if1.bus_src), 32'(tbl[i].s1));
            chk($sformatf("v%0d u1.bus_out", i), if1.bus_out, word(int'(tbl[i].s1)));
            chk($sformatf("v%0d u0.valid", i), 32'(if0.bus_valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d u1.valid", i), 32'(if1.bus_valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d u0.conflict", i), 32'(if0.conflict), 32'(tbl[i].conf));
            chk($sformatf("v%0d u1.conflict", i), 32'(if1.conflict), 32'(tbl[i].conf));
            chk($sformatf("v%0d u0.cnt", i), 32'(if0.conflict_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d u1.cnt", i), 32'(if1.conflict_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d u2.cnt", i), 32'(if2.conflict_cnt), 32'(tbl[i].cnt[3:0]));
        end
        clr = 1'b0;

        // Asynchronous reset between edges while conflicts are being counted
        oe = 8'hFF;
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("arst u0.bus_out", if0.bus_out, 32'h0);
        chk("arst u0.bus_src", 32'(if0.bus_src), 32'd0);
        chk("arst u0.valid", 32'(if0.bus_valid), 32'd0);
        chk("arst u0.conflict", 32'(if0.conflict), 32'd0);
        chk("arst u0.cnt", 32'(if0.conflict_cnt), 32'd0);
        chk("arst u1.bus_out", if1.bus_out, 32'h0);
        chk("arst u1.bus_src", 32'(if1.bus_src), 32'd0);
        chk("arst u2.cnt", 32'(if2.conflict_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("arst first rr grant", 32'(if1.bus_src), 32'd0);
        chk("arst first rr data", if1.bus_out, 32'hA0A0_A0A0);
        chk("arst first fixed grant", 32'(if0.bus_src), 32'd7);

        // Round-robin rotation from reset
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        rot[0] = 3'd0; rot[1] = 3'd3; rot[2] = 3'd0; rot[3] = 3'd3;
        oe = 8'h09;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rot%0d u1.src", k), 32'(if1.bus_src), 32'(rot[k]));
            chk($sformatf("rot%0d u1.conflict", k), 32'(if1.conflict), 32'd1);
        end
        chk("rot u1.cnt", 32'(if1.conflict_cnt), 32'd4);

        // Saturation of the 4-bit counter, then clear with and without a conflict
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        oe = 8'h03;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 14) chk("sat14 u2.cnt", 32'(if2.conflict_cnt), 32'd14);
            if (n == 15) chk("sat15 u2.cnt", 32'(if2.conflict_cnt), 32'd15);
            if (n == 20) chk("sat20 u2.cnt", 32'(if2.conflict_cnt), 32'd15);
        end
        chk("sat20 u0.cnt", 32'(if0.conflict_cnt), 32'd20);
        clr = 1'b1;
        step();
        chk("clr+conf u2.cnt", 32'(if2.conflict_cnt), 32'd1);
        chk("clr+conf u0.cnt", 32'(if0.conflict_cnt), 32'd1);
        oe = 8'h00;
        step();
        chk("clr u2.cnt", 32'(if2.conflict_cnt), 32'd0);
        chk("clr u0.cnt", 32'(if0.conflict_cnt), 32'd0);
        chk("clr u0.conflict", 32'(if0.conflict), 32'd0);
        clr = 1'b0;

        // Wrap from rr_last = 7 to source 0 with unselected words at X
        set_words();
        oe = 8'h80;
        step();
        chk("wrap pre u1.src", 32'(if1.bus_src), 32'd7);
        for (int k = 1; k < 8; k++) sdata[k*32 +: 32] = 'x;
        oe = 8'h81;
        step();
        chk("wrap u1.src", 32'(if1.bus_src), 32'd0);
        chk("wrap u1.bus_out", if1.bus_out, 32'hA0A0_A0A0);
        chk("wrap u1.no_x", 32'($isunknown(if1.bus_out)), 32'd0);
        chk("wrap u0.src", 32'(if0.bus_src), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_reg.md
Name: bus_arbiter_reg

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NSRC source words onto the shared WIDTH-bit internal bus and registers the result.
- Holds the last driven value when no source enables its output.
- Detects and counts output-enable conflicts, and offers fixed-priority or round-robin resolution.
- Sits between the register file, PC/IR/MAR/MDR outputs and all bus consumers.

Parameters:
- WIDTH, 32: bus data width in bits.
- NSRC, 8: number of bus sources; 2..32.
- MODE, 0: conflict resolution. 0 = fixed priority, highest index wins. 1 = round-robin.
- CNT_W, 8: width of the saturating conflict counter.
- SEL_W, $clog2(NSRC): width of the source index (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_data  in  NSRC*WIDTH  packed source words; source i occupies bits [i*WIDTH +: WIDTH].
- src_oe  in  NSRC  per-source output enable; the encoder normally drives it one-hot.
- clr_err  in  1  synchronous clear of conflict_cnt.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  high for one cycle after a cycle in which any src_oe was high.
- bus_src  out  SEL_W  index of the source that drove bus_out.
- conflict  out  1  registered pulse: previous cycle had two or more src_oe bits high.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - bus_out = 0, bus_valid = 0, bus_src = 0, conflict = 0, conflict_cnt = 0
  - round-robin pointer rr_last = NSRC-1, so source 0 has first priority after reset.
- Release from reset is synchronous to the next rising clk edge. All outputs are registered.
- Latency: src_oe/src_data sampled at edge N appear on the outputs after edge N; one-cycle latency.
- No src_oe bit high:
  - bus_out and bus_src hold their previous values; the bus never floats and never returns to 0.
  - bus_valid = 0, conflict = 0, rr_last unchanged.
- Exactly one bit k high:
  - bus_out = src_data[k], bus_src = k, bus_valid = 1, conflict = 0.
  - Identical result in both modes.
- Two or more bits high, MODE 0:
  - The highest set index wins, which preserves the legacy "last enable wins" ordering.
  - conflict = 1.
- Two or more bits high, MODE 1:
  - Winner is the first set bit scanning rr_last+1, rr_last+2, ... with wrap from NSRC-1 to 0.
  - conflict = 1.
- rr_last update:
  - Updated to the winner index on every cycle with bus_valid_next = 1, including single-source cycles.
  - In MODE 0, rr_last is unused and is held at its reset value.
- conflict_cnt:
  - Increments by 1 on each conflict cycle and saturates at 2^CNT_W-1 (no wrap).
  - If clr_err and a conflict occur in the same cycle, the counter is set to 1 (clear, then count).
  - clr_err alone sets it to 0.
- src_data of non-selected sources is don't-care. X on an unselected word must not propagate to bus_out.
- Reset asserted mid-transfer overrides everything immediately. The in-flight value is discarded.
- Winner selection is purely combinational from src_oe and rr_last. No multi-cycle grant and no handshake: the source owns the bus for exactly the cycles its oe is high.

Decomposition:
- Shared package constants: BUS_WIDTH = 32, source-index constants (SRC_PC, SRC_IR, SRC_MAR, SRC_MDR, SRC_R0 ...), and the mode constants ARB_FIXED = 0 and ARB_RR = 1.
- Sub-module prio_pick:
  - Inputs: request vector, start index.
  - Outputs: winner index and any-request flag.
  - MODE 0 instantiates it with start fixed to 0 and the vector bit-reversed.
  - MODE 1 instantiates it with start = rr_last+1 mod NSRC.
- The top level contains the data mux, registers, pointer and counter.

Test Plan:
- Reset then single source:
  - Stimulus: rst_n low 3 cycles; release; src_oe = 8'b0000_0100, src_data[2] = 32'hDEADBEEF for 1 cycle.
  - Response: after that edge bus_out = DEADBEEF, bus_src = 2, bus_valid = 1, conflict = 0. Next cycle, with src_oe = 0, bus_out stays DEADBEEF and bus_valid = 0.
- MODE 0 conflict:
  - Stimulus: src_oe = 8'b0001_0010, src_data[1] = 1111_1111, src_data[4] = 4444_4444.
  - Response: bus_out = 44444444, bus_src = 4, conflict = 1, conflict_cnt = 1.
- MODE 1 rotation:
  - Stimulus: src_oe = 8'b0000_1001 held 4 cycles from reset.
  - Response: bus_src sequence 0, 3, 0, 3; conflict = 1 each cycle; conflict_cnt = 4.
- Counter saturation and clear:
  - Stimulus: CNT_W = 4; 20 conflict cycles; then clr_err with a conflict in the same cycle; then clr_err alone.
  - Response: cnt reaches 15 and holds; then cnt = 1; then cnt = 0.
- Async reset mid-operation:
  - Stimulus: drive conflicts; assert rst_n low between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge; the first post-release MODE 1 grant with src_oe = 8'hFF is index 0.
- Wrap-around and X isolation:
  - Stimulus: MODE 1, rr_last = 7; src_oe = 8'b1000_0001; unselected src_data words = X.
  - Response: winner is 0, and bus_out contains no X.
